// File: rtl/csr_trap_sequencer.sv
// Machine-mode trap sequencer: saves mepc/mcause on ecall or timer interrupt, fetches
// mtvec/mepc from the CSR file and hands the new fetch PC to the front end.
module csr_trap_sequencer #(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  ECALL_CAUSE = XLEN'(11),
    parameter logic [XLEN-1:0]  TIMER_CAUSE = {1'b1, {(XLEN - 4){1'b0}}, 3'd7}
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_ecall,
    input  logic            commit_mret,
    input  logic            timer_interrupt,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_ren,
    output logic [11:0]     csr_raddr,
    output logic            csr_wen1,
    output logic [11:0]     csr_waddr1,
    output logic [XLEN-1:0] csr_wdata1,
    output logic            csr_wen2,
    output logic [11:0]     csr_waddr2,
    output logic [XLEN-1:0] csr_wdata2,
    output logic            csr_ecall,
    output logic            csr_mret,
    output logic            handle_timer_intr,
    output logic            busy,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    localparam logic [11:0] AddrMtvec  = 12'h305;
    localparam logic [11:0] AddrMepc   = 12'h341;
    localparam logic [11:0] AddrMcause = 12'h342;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StLoadTvec,
        StLoadEpc,
        StRedirect
    } state_e;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            intr_q, intr_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic evt_intr, evt_ecall, evt_mret, evt_any;
    logic [XLEN-1:0] rdata_aligned;
    logic unused_rdata_lsbs;

    // Priority: timer interrupt > ecall > mret; nothing is taken without commit_valid.
    assign evt_intr  = commit_valid & timer_interrupt;
    assign evt_ecall = commit_valid & commit_ecall & ~timer_interrupt;
    assign evt_mret  = commit_valid & commit_mret & ~commit_ecall & ~timer_interrupt;
    assign evt_any   = evt_intr | evt_ecall | evt_mret;

    // Direct mode only: MODE bits of mtvec (and low bits of mepc) are dropped.
    assign rdata_aligned     = {csr_rdata[XLEN-1:2], 2'b00};
    assign unused_rdata_lsbs = ^csr_rdata[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            intr_q        <= 1'b0;
            epc_q         <= '0;
            cause_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            intr_q        <= intr_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        intr_d        = intr_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (evt_intr || evt_ecall) begin
                    epc_d   = commit_pc;
                    cause_d = evt_intr ? TIMER_CAUSE : ECALL_CAUSE;
                    intr_d  = evt_intr;
                    busy_d  = 1'b1;
                    state_d = StSave;
                end else if (evt_mret) begin
                    busy_d  = 1'b1;
                    state_d = StLoadEpc;
                end
            end
            StSave: begin
                state_d = StLoadTvec;
            end
            StLoadTvec, StLoadEpc: begin
                redirect_pc_d = rdata_aligned;
                state_d       = StRedirect;
            end
            StRedirect: begin
                if (redirect_ready) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        csr_ren           = 1'b0;
        csr_raddr         = '0;
        csr_wen1          = 1'b0;
        csr_waddr1        = '0;
        csr_wdata1        = '0;
        csr_wen2          = 1'b0;
        csr_waddr2        = '0;
        csr_wdata2        = '0;
        csr_ecall         = 1'b0;
        csr_mret          = 1'b0;
        handle_timer_intr = 1'b0;
        redirect_valid    = 1'b0;
        flush             = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gated by reset so that flush is also quiet while reset is held.
                flush = evt_any & reset;
            end
            StSave: begin
                csr_wen1          = 1'b1;
                csr_waddr1        = AddrMepc;
                csr_wdata1        = epc_q;
                csr_wen2          = 1'b1;
                csr_waddr2        = AddrMcause;
                csr_wdata2        = cause_q;
                handle_timer_intr = intr_q;
                csr_ecall         = ~intr_q;
            end
            StLoadTvec: begin
                csr_ren   = 1'b1;
                csr_raddr = AddrMtvec;
            end
            StLoadEpc: begin
                csr_ren   = 1'b1;
                csr_raddr = AddrMepc;
                csr_mret  = 1'b1;
            end
            StRedirect: begin
                redirect_valid = 1'b1;
            end
            default: begin
                flush = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: directed plan steps followed by randomized trap/return
// transactions, each checked cycle by cycle against a transaction-level expectation.
module tb_csr_trap_sequencer;

    localparam int XLEN = 64;
    localparam logic [63:0] TimerCause = 64'h8000_0000_0000_0007;
    localparam logic [63:0] EcallCause = 64'd11;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            commit_valid = 1'b0;
    logic [XLEN-1:0] commit_pc = '0;
    logic            commit_ecall = 1'b0;
    logic            commit_mret = 1'b0;
    logic            timer_interrupt = 1'b0;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_ren;
    logic [11:0]     csr_raddr;
    logic            csr_wen1, csr_wen2;
    logic [11:0]     csr_waddr1, csr_waddr2;
    logic [XLEN-1:0] csr_wdata1, csr_wdata2;
    logic            csr_ecall, csr_mret, handle_timer_intr;
    logic            busy, flush, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready = 1'b0;

    logic [63:0] tvec_val = '0;
    logic [63:0] epc_val  = '0;

    csr_trap_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_ecall     (commit_ecall),
        .commit_mret      (commit_mret),
        .timer_interrupt  (timer_interrupt),
        .csr_rdata        (csr_rdata),
        .csr_ren          (csr_ren),
        .csr_raddr        (csr_raddr),
        .csr_wen1         (csr_wen1),
        .csr_waddr1       (csr_waddr1),
        .csr_wdata1       (csr_wdata1),
        .csr_wen2         (csr_wen2),
        .csr_waddr2       (csr_waddr2),
        .csr_wdata2       (csr_wdata2),
        .csr_ecall        (csr_ecall),
        .csr_mret         (csr_mret),
        .handle_timer_intr(handle_timer_intr),
        .busy             (busy),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_ready   (redirect_ready)
    );

    always #5 clock = ~clock;

    // Minimal CSR file: answers mtvec and mepc reads combinationally.
    assign csr_rdata = (csr_raddr == 12'h305) ? tvec_val :
                       (csr_raddr == 12'h341) ? epc_val  : 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct packed {
        logic        flush;
        logic        busy;
        logic        wen1;
        logic [11:0] waddr1;
        logic [63:0] wdata1;
        logic        wen2;
        logic [11:0] waddr2;
        logic [63:0] wdata2;
        logic        ren;
        logic [11:0] raddr;
        logic        ecall;
        logic        mret;
        logic        hti;
        logic        rv;
        logic [63:0] rpc;
    } obs_t;

    int tests = 0;
    int fails = 0;
    logic [63:0] last_rpc = '0;

    function automatic obs_t sample();
        obs_t o;
        o.flush  = flush;
        o.busy   = busy;
        o.wen1   = csr_wen1;
        o.waddr1 = csr_waddr1;
        o.wdata1 = csr_wdata1;
        o.wen2   = csr_wen2;
        o.waddr2 = csr_waddr2;
        o.wdata2 = csr_wdata2;
        o.ren    = csr_ren;
        o.raddr  = csr_raddr;
        o.ecall  = csr_ecall;
        o.mret   = csr_mret;
        o.hti    = handle_timer_intr;
        o.rv     = redirect_valid;
        o.rpc    = redirect_pc;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = sample();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs are already driven just after a negedge; check, then move to the next negedge.
    task automatic cyc(input string tag, input obs_t exp);
        #1;
        check(tag, exp);
        @(negedge clock);
    endtask

    // Noise on commit/ready inputs while the sequencer is busy; all of it must be ignored.
    task automatic junk();
        commit_valid    = 1'($urandom_range(0, 1));
        commit_ecall    = 1'($urandom_range(0, 1));
        commit_mret     = 1'($urandom_range(0, 1));
        timer_interrupt = 1'($urandom_range(0, 1));
        commit_pc       = {$urandom, $urandom};
        redirect_ready  = 1'($urandom_range(0, 1));
    endtask

    function automatic obs_t idle_exp();
        obs_t e;
        e     = '0;
        e.rpc = last_rpc;
        return e;
    endfunction

    // One commit-point transaction. abort=1 asserts reset in the middle of the mtvec fetch.
    task automatic run_txn(input string name, input bit cv, input bit ec, input bit mr,
                           input bit ti, input logic [63:0] pc, input logic [63:0] tvec,
                           input logic [63:0] epc, input int delay, input bit abort);
        obs_t e;
        int   kind;  // 0 none, 1 interrupt, 2 ecall, 3 mret
        tvec_val        = tvec;
        epc_val         = epc;
        commit_valid    = cv;
        commit_ecall    = ec;
        commit_mret     = mr;
        timer_interrupt = ti;
        commit_pc       = pc;
        redirect_ready  = 1'($urandom_range(0, 1));
        if (!cv)      kind = 0;
        else if (ti)  kind = 1;
        else if (ec)  kind = 2;
        else if (mr)  kind = 3;
        else          kind = 0;

        e       = idle_exp();
        e.flush = (kind != 0);
        cyc({name, " accept"}, e);
        if (kind == 0) return;

        if (kind != 3) begin
            junk();
            e        = idle_exp();
            e.busy   = 1'b1;
            e.wen1   = 1'b1;
            e.waddr1 = 12'h341;
            e.wdata1 = pc;
            e.wen2   = 1'b1;
            e.waddr2 = 12'h342;
            e.wdata2 = (kind == 1) ? TimerCause : EcallCause;
            e.hti    = (kind == 1);
            e.ecall  = (kind == 2);
            cyc({name, " save"}, e);
            junk();
            e       = idle_exp();
            e.busy  = 1'b1;
            e.ren   = 1'b1;
            e.raddr = 12'h305;
            if (abort) begin
                #1;
                check({name, " load_tvec"}, e);
                #2;
                reset = 1'b0;
                #1;
                last_rpc = '0;
                check({name, " reset async"}, idle_exp());
                @(negedge clock);
                junk();
                cyc({name, " reset held"}, idle_exp());
                reset        = 1'b1;
                commit_valid = 1'b0;
                cyc({name, " after release"}, idle_exp());
                cyc({name, " after release 2"}, idle_exp());
                return;
            end
            cyc({name, " load_tvec"}, e);
            last_rpc = tvec & ~64'h3;
        end else begin
            junk();
            e       = idle_exp();
            e.busy  = 1'b1;
            e.ren   = 1'b1;
            e.raddr = 12'h341;
            e.mret  = 1'b1;
            cyc({name, " load_epc"}, e);
            last_rpc = epc & ~64'h3;
        end

        e      = idle_exp();
        e.busy = 1'b1;
        e.rv   = 1'b1;
        for (int i = 0; i < delay; i++) begin
            junk();
            redirect_ready = 1'b0;
            cyc($sformatf("%s redirect wait %0d", name, i), e);
        end
        junk();
        redirect_ready = 1'b1;
        cyc({name, " redirect take"}, e);
        commit_valid   = 1'b0;
        redirect_ready = 1'b0;
    endtask

    initial begin
        // Reset held with an ecall presented: everything, flush included, stays 0.
        commit_valid = 1'b1;
        commit_ecall = 1'b1;
        commit_pc    = 64'h1234;
        #1;
        check("reset t0", idle_exp());
        @(negedge clock);
        cyc("reset held", idle_exp());
        reset        = 1'b1;
        commit_valid = 1'b0;
        commit_ecall = 1'b0;
        cyc("idle after reset", idle_exp());

        run_txn("ecall", 1, 1, 0, 0, 64'h8000_0010, 64'h8000_1001, 64'h0, 0, 0);
        run_txn("mret", 1, 0, 1, 0, 64'h8000_0050, 64'h0, 64'h8000_0014, 0, 0);
        run_txn("timer+ecall", 1, 1, 0, 1, 64'h8000_0020, 64'h8000_2000, 64'h0, 0, 0);
        run_txn("backpressure", 1, 1, 0, 0, 64'h8000_0030, 64'h8000_3003, 64'h0, 4, 0);
        cyc("idle after backpressure", idle_exp());
        run_txn("ecall+mret", 1, 1, 1, 0, 64'h8000_0040, 64'h8000_4002, 64'h8000_0099, 1, 0);
        run_txn("timer no valid", 0, 0, 0, 1, 64'h8000_0060, 64'h0, 64'h0, 0, 0);
        timer_interrupt = 1'b1;
        cyc("timer still no valid", idle_exp());
        run_txn("timer taken", 1, 0, 0, 1, 64'h8000_0064, 64'h8000_5000, 64'h0, 2, 0);
        run_txn("reset abort", 1, 1, 0, 0, 64'h8000_0070, 64'h8000_6000, 64'h0, 0, 1);
        run_txn("ecall post reset", 1, 1, 0, 0, 64'h8000_0074, 64'h8000_7001, 64'h0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            run_txn($sformatf("rand%0d", n), ($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), 0);
        end
        commit_valid = 1'b0;
        cyc("final idle", idle_exp());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Sequences the machine-mode CSR file for trap entry (ecall, timer interrupt) and trap return (mret).
- Accepts trap events from the commit stage and stalls/flushes the pipeline.
- Drives the CSR file's two write ports and read port to save mepc/mcause and fetch mtvec/mepc, then issues a PC redirect with a valid/ready handshake.
- Sits between the commit stage, the CSR register file and the fetch unit.

Parameters:
- XLEN, 64, data/PC width.
- ECALL_CAUSE, 11, mcause value written for an M-mode ecall.
- TIMER_CAUSE, 64'h8000_0000_0000_0007, mcause value written for a machine timer interrupt (interrupt bit set).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- commit_valid  in  1  an instruction is at the commit point this cycle
- commit_pc  in  XLEN  PC of the committing instruction
- commit_ecall  in  1  committing instruction is ecall
- commit_mret  in  1  committing instruction is mret
- timer_interrupt  in  1  pending timer interrupt (mip.MTIP, already gated by MIE/mie in the CSR file)
- csr_rdata  in  XLEN  CSR file read data (combinational)
- csr_ren  out  1  CSR read enable
- csr_raddr  out  12  CSR read address
- csr_wen1 / csr_waddr1 / csr_wdata1  out  1/12/XLEN  CSR write port 1
- csr_wen2 / csr_waddr2 / csr_wdata2  out  1/12/XLEN  CSR write port 2
- csr_ecall  out  1  one-cycle pulse: CSR file performs the mstatus trap-entry update
- csr_mret  out  1  one-cycle pulse: CSR file performs the mstatus return update
- handle_timer_intr  out  1  one-cycle pulse: CSR file clears MTIP
- busy  out  1  sequencer active; the commit stage must hold
- flush  out  1  one-cycle pulse: kill all younger in-flight instructions
- redirect_valid  out  1  redirect target valid
- redirect_pc  out  XLEN  new fetch PC
- redirect_ready  in  1  fetch unit accepts the redirect

Behaviour:
- States: IDLE, SAVE, LOAD_TVEC, LOAD_EPC, REDIRECT.
- Reset (reset==0, asynchronous): state=IDLE. All outputs are 0, including redirect_pc and the internal epc/cause latches. Reset mid-sequence aborts with no further CSR writes.
- Event acceptance happens only in IDLE, when commit_valid=1. Priority is timer_interrupt > commit_ecall > commit_mret.
  - Interrupt taken: epc=commit_pc (that instruction is not executed), cause=TIMER_CAUSE; go to SAVE.
  - Ecall: epc=commit_pc, cause=ECALL_CAUSE; go to SAVE.
  - Mret: go to LOAD_EPC.
  - Accept cycle: flush=1 for exactly this cycle. busy is registered, so it asserts in the following cycle and stays high until REDIRECT completes.
- No commit_valid: no event is taken, even if timer_interrupt=1.
- SAVE (1 cycle):
  - csr_wen1=1, csr_waddr1=12'h341, csr_wdata1=epc.
  - csr_wen2=1, csr_waddr2=12'h342, csr_wdata2=cause.
  - Interrupt: handle_timer_intr=1. Ecall: csr_ecall=1.
  - Next state: LOAD_TVEC.
- LOAD_TVEC (1 cycle): csr_ren=1, csr_raddr=12'h305. Register redirect_pc={csr_rdata[XLEN-1:2],2'b00} (direct mode only; MODE bits ignored). Next state: REDIRECT.
- LOAD_EPC (1 cycle): csr_ren=1, csr_raddr=12'h341, csr_mret=1. Register redirect_pc={csr_rdata[XLEN-1:2],2'b00}. Next state: REDIRECT.
- REDIRECT: redirect_valid=1 with redirect_pc held stable. Stay here until redirect_ready=1; in that cycle go to IDLE. busy deasserts from the next cycle.
- redirect_ready while not in REDIRECT: ignored.
- Trap entry latency: accept to redirect_valid is 3 cycles. Mret latency: 2 cycles.
- All CSR strobes are single-cycle. No CSR port is driven outside its state; addresses and data are 0 when the matching enable is 0.
- Simultaneous events:
  - timer_interrupt with commit_ecall: the interrupt wins; the ecall PC is saved as mepc and re-executes after return.
  - commit_ecall with commit_mret: illegal input; ecall wins.
- A timer_interrupt arriving while busy is not sampled until the next IDLE acceptance.

Test Plan:
- Ecall: commit_pc=0x8000_0010, commit_ecall=1 → flush pulse; SAVE writes 0x341←0x8000_0010 and 0x342←11 with csr_ecall=1; csr_rdata(0x305)=0x8000_1001 → redirect_pc=0x8000_1000 three cycles after accept.
- Mret: commit_mret=1, csr_rdata(0x341)=0x8000_0014 → csr_mret pulse in LOAD_EPC; redirect_valid with redirect_pc=0x8000_0014 two cycles after accept; no write strobes at any point.
- Timer vs ecall same cycle at pc=0x8000_0020 → mcause=0x8000_0000_0000_0007, mepc=0x8000_0020, handle_timer_intr=1, csr_ecall=0.
- Redirect backpressure: redirect_ready low for 4 cycles → redirect_valid and redirect_pc held and busy stays high; one cycle after ready rises, state is IDLE and busy=0.
- Reset driven low during LOAD_TVEC → all outputs 0 immediately; no further CSR strobes after reset release; next ecall is sequenced normally.
- timer_interrupt=1 with commit_valid=0 → no flush and no strobes; commit_valid raised later → interrupt taken with epc=commit_pc of that cycle.
